// File: rtl/tlul_host_arb_pkg.sv
// Shared types for the two-host TL-UL arbiter: bus payloads, host IDs and arbiter states.
package tlul_host_arb_pkg;

   localparam int unsigned MaxOutstandingDefault = 4;

   localparam int unsigned TlAddrW   = 32;
   localparam int unsigned TlDataW   = 32;
   localparam int unsigned TlSourceW = 8;
   localparam int unsigned TlMaskW   = TlDataW / 8;

   typedef struct packed {
      logic                 a_valid;
      logic [2:0]           a_opcode;
      logic [2:0]           a_param;
      logic [1:0]           a_size;
      logic [TlSourceW-1:0] a_source;
      logic [TlAddrW-1:0]   a_address;
      logic [TlMaskW-1:0]   a_mask;
      logic [TlDataW-1:0]   a_data;
      logic                 d_ready;
   } tlul_h2d_t;

   typedef struct packed {
      logic                 d_valid;
      logic [2:0]           d_opcode;
      logic [2:0]           d_param;
      logic [1:0]           d_size;
      logic [TlSourceW-1:0] d_source;
      logic                 d_sink;
      logic [TlDataW-1:0]   d_data;
      logic                 d_error;
      logic                 a_ready;
   } tlul_d2h_t;

   typedef logic host_id_t;

   localparam host_id_t HostH0 = 1'b0;
   localparam host_id_t HostH1 = 1'b1;

   typedef enum logic [1:0] {
      ArbIdle   = 2'd0,
      ArbLockH0 = 2'd1,
      ArbLockH1 = 2'd2
   } arb_state_e;

endpackage

// File: rtl/tlul_arb_id_fifo.sv
// Synchronous FIFO recording which host owns each outstanding request; a push
// is accepted while full when a pop happens in the same cycle.
module tlul_arb_id_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [CntW-1:0]  cnt_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign rdata_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (do_push && !do_pop) begin
            cnt_q <= cnt_q + CntW'(1);
         end else if (do_pop && !do_push) begin
            cnt_q <= cnt_q - CntW'(1);
         end
      end
   end

   // Storage needs no reset; the count alone defines validity.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/tlul_host_arb.sv
// Two-host TL-UL arbiter onto one in-order device, round-robin with grant lock.
// Optional grant counters are enabled with the TLUL_HOST_ARB_PERF_EN macro.
module tlul_host_arb
   import tlul_host_arb_pkg::*;
#(
   parameter int unsigned MaxOutstanding = MaxOutstandingDefault
) (
   input  logic        clk_i,
   input  logic        rst_i,
`ifdef TLUL_HOST_ARB_PERF_EN
   output logic [15:0] gnt_cnt0_o,
   output logic [15:0] gnt_cnt1_o,
`endif
   input  tlul_h2d_t   tl_h0_i,
   output tlul_d2h_t   tl_h0_o,
   input  tlul_h2d_t   tl_h1_i,
   output tlul_d2h_t   tl_h1_o,
   output tlul_h2d_t   tl_d_o,
   input  tlul_d2h_t   tl_d_i
);

   localparam logic [1:0] StIdle   = 2'(ArbIdle);
   localparam logic [1:0] StLockH0 = 2'(ArbLockH0);
   localparam logic [1:0] StLockH1 = 2'(ArbLockH1);

   logic [1:0] state_q;
   logic [1:0] state_d;
   host_id_t   last_gnt_q;
   host_id_t   gnt;
   logic       gnt_valid;
   tlul_h2d_t  sel_req;
   logic       sel_valid;
   logic       can_accept;
   logic       a_valid_out;
   logic       a_hs;
   logic       dev_d_ready;
   logic       pop;
   host_id_t   head;
   logic       fifo_full;
   logic       fifo_empty;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         last_gnt_q <= HostH1;
      end else begin
         state_q <= state_d;
         if (a_hs) last_gnt_q <= gnt;
      end
   end

   // Grant selection, next state, and channel muxing.
   always_comb begin
      gnt_valid   = 1'b0;
      gnt         = HostH0;
      state_d     = StIdle;
      sel_req     = tl_h0_i;
      sel_valid   = 1'b0;
      dev_d_ready = 1'b1;
      pop         = 1'b0;
      can_accept  = 1'b0;
      a_valid_out = 1'b0;
      a_hs        = 1'b0;

      case (state_q)
         StLockH0: begin
            gnt_valid = 1'b1;
            gnt       = HostH0;
         end
         StLockH1: begin
            gnt_valid = 1'b1;
            gnt       = HostH1;
         end
         default: begin
            if (tl_h0_i.a_valid && tl_h1_i.a_valid) begin
               gnt_valid = 1'b1;
               gnt       = (last_gnt_q == HostH1) ? HostH0 : HostH1;
            end else if (tl_h0_i.a_valid) begin
               gnt_valid = 1'b1;
               gnt       = HostH0;
            end else if (tl_h1_i.a_valid) begin
               gnt_valid = 1'b1;
               gnt       = HostH1;
            end
         end
      endcase

      sel_req   = (gnt == HostH1) ? tl_h1_i : tl_h0_i;
      sel_valid = gnt_valid & sel_req.a_valid;

      // An empty FIFO means nobody owns the response: sink it.
      if (!rst_i && !fifo_empty) begin
         dev_d_ready = (head == HostH1) ? tl_h1_i.d_ready : tl_h0_i.d_ready;
      end
      pop = ~rst_i & tl_d_i.d_valid & dev_d_ready & ~fifo_empty;

      can_accept  = ~fifo_full | pop;
      a_valid_out = ~rst_i & sel_valid & can_accept;
      a_hs        = a_valid_out & tl_d_i.a_ready;

      if (sel_valid && !a_hs) begin
         state_d = (gnt == HostH1) ? StLockH1 : StLockH0;
      end

      tl_d_o         = sel_req;
      tl_d_o.a_valid = a_valid_out;
      tl_d_o.d_ready = dev_d_ready;

      tl_h0_o         = tl_d_i;
      tl_h0_o.a_ready = ~rst_i & gnt_valid & (gnt == HostH0) & can_accept & tl_d_i.a_ready;
      tl_h0_o.d_valid = ~rst_i & tl_d_i.d_valid & ~fifo_empty & (head == HostH0);

      tl_h1_o         = tl_d_i;
      tl_h1_o.a_ready = ~rst_i & gnt_valid & (gnt == HostH1) & can_accept & tl_d_i.a_ready;
      tl_h1_o.d_valid = ~rst_i & tl_d_i.d_valid & ~fifo_empty & (head == HostH1);
   end

   tlul_arb_id_fifo #(
      .Depth (MaxOutstanding),
      .Width ($bits(host_id_t))
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (a_hs),
      .wdata_i (gnt),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

`ifdef TLUL_HOST_ARB_PERF_EN
   // Saturating per-host grant counters.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gnt_cnt0_o <= '0;
         gnt_cnt1_o <= '0;
      end else if (a_hs) begin
         if (gnt == HostH0 && gnt_cnt0_o != 16'hFFFF) gnt_cnt0_o <= gnt_cnt0_o + 16'd1;
         if (gnt == HostH1 && gnt_cnt1_o != 16'hFFFF) gnt_cnt1_o <= gnt_cnt1_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tlul_host_arb.sv
// Directed self-checking bench for tlul_host_arb with the default depth of 4.
module tb_tlul_host_arb;
   import tlul_host_arb_pkg::*;

   logic      clk;
   logic      rst;
   tlul_h2d_t h0;
   tlul_h2d_t h1;
   tlul_d2h_t dev;
   tlul_d2h_t h0_rsp;
   tlul_d2h_t h1_rsp;
   tlul_h2d_t dev_req;
`ifdef TLUL_HOST_ARB_PERF_EN
   logic [15:0] cnt0;
   logic [15:0] cnt1;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   tlul_host_arb #(.MaxOutstanding(4)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
`ifdef TLUL_HOST_ARB_PERF_EN
      .gnt_cnt0_o (cnt0),
      .gnt_cnt1_o (cnt1),
`endif
      .tl_h0_i    (h0),
      .tl_h0_o    (h0_rsp),
      .tl_h1_i    (h1),
      .tl_h1_o    (h1_rsp),
      .tl_d_o     (dev_req),
      .tl_d_i     (dev)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   function automatic tlul_h2d_t mk_get(input logic [31:0] addr, input logic [7:0] src);
      tlul_h2d_t r;
      r           = '0;
      r.a_valid   = 1'b1;
      r.a_opcode  = 3'd4;
      r.a_size    = 2'd2;
      r.a_source  = src;
      r.a_address = addr;
      r.a_mask    = 4'hF;
      r.d_ready   = 1'b1;
      return r;
   endfunction

   task automatic hosts_idle();
      h0 = '0; h0.d_ready = 1'b1;
      h1 = '0; h1.d_ready = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      hosts_idle();
      dev = '0; dev.a_ready = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic respond(input logic [31:0] data, input logic [7:0] src);
      dev          = '0;
      dev.a_ready  = 1'b1;
      dev.d_valid  = 1'b1;
      dev.d_opcode = 3'd1;
      dev.d_data   = data;
      dev.d_source = src;
   endtask

   initial begin
      // Reset holds everything quiet even with traffic present.
      rst = 1'b1;
      h0  = mk_get(32'h1000_0000, 8'd0);
      h1  = mk_get(32'h2000_0000, 8'd1);
      respond(32'h1234_5678, 8'd0);
      settle(); settle();
      chk("rst_dev_a_valid", 64'(dev_req.a_valid), 64'd0);
      chk("rst_h0_a_ready",  64'(h0_rsp.a_ready),  64'd0);
      chk("rst_h1_a_ready",  64'(h1_rsp.a_ready),  64'd0);
      chk("rst_h0_d_valid",  64'(h0_rsp.d_valid),  64'd0);
      chk("rst_h1_d_valid",  64'(h1_rsp.d_valid),  64'd0);
      chk("rst_d_ready",     64'(dev_req.d_ready), 64'd1);
      tick();
      do_reset();

      // Single host-0 read granted in the same cycle, response only to host 0.
      h0 = mk_get(32'h1000_0000, 8'd3);
      settle();
      chk("single_a_valid", 64'(dev_req.a_valid),   64'd1);
      chk("single_addr",    64'(dev_req.a_address), 64'h1000_0000);
      chk("single_src",     64'(dev_req.a_source),  64'd3);
      chk("single_h0_rdy",  64'(h0_rsp.a_ready),    64'd1);
      chk("single_h1_rdy",  64'(h1_rsp.a_ready),    64'd0);
      tick();
      hosts_idle();
      respond(32'hDEAD_BEEF, 8'd3);
      settle();
      chk("single_h0_dv",   64'(h0_rsp.d_valid), 64'd1);
      chk("single_h0_data", 64'(h0_rsp.d_data),  64'hDEAD_BEEF);
      chk("single_h1_dv",   64'(h1_rsp.d_valid), 64'd0);
      chk("single_d_ready", 64'(dev_req.d_ready), 64'd1);
      tick();
      dev = '0; dev.a_ready = 1'b1;

      // Both hosts requesting every cycle alternate, starting with host 0.
      do_reset();
      h0 = mk_get(32'h1000_0000, 8'd0);
      h1 = mk_get(32'h2000_0000, 8'd1);
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("rr_h0_rdy", 64'(h0_rsp.a_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
         chk("rr_h1_rdy", 64'(h1_rsp.a_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
         chk("rr_addr", 64'(dev_req.a_address), (i % 2 == 0) ? 64'h1000_0000 : 64'h2000_0000);
         tick();
      end
`ifdef TLUL_HOST_ARB_PERF_EN
      chk("rr_cnt0", 64'(cnt0), 64'd2);
      chk("rr_cnt1", 64'(cnt1), 64'd2);
`endif
      // FIFO now full: no A traffic, lock on host 0 retained.
      settle();
      chk("full_a_valid", 64'(dev_req.a_valid), 64'd0);
      chk("full_h0_rdy",  64'(h0_rsp.a_ready),  64'd0);
      chk("full_h1_rdy",  64'(h1_rsp.a_ready),  64'd0);
      chk("full_addr",    64'(dev_req.a_address), 64'h1000_0000);
      tick();
      hosts_idle();
      // Head owner backpressure reaches the device.
      respond(32'hA0, 8'd0);
      h0.d_ready = 1'b0;
      settle();
      chk("drain_d_ready_bp", 64'(dev_req.d_ready), 64'd0);
      tick();
      h0.d_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("drain_h0_dv", 64'(h0_rsp.d_valid), (i % 2 == 0) ? 64'd1 : 64'd0);
         chk("drain_h1_dv", 64'(h1_rsp.d_valid), (i % 2 == 0) ? 64'd0 : 64'd1);
         tick();
      end
      settle();
      chk("drain_spur_d_ready", 64'(dev_req.d_ready), 64'd1);
      chk("drain_spur_h0_dv",   64'(h0_rsp.d_valid),  64'd0);
      chk("drain_spur_h1_dv",   64'(h1_rsp.d_valid),  64'd0);
      dev = '0; dev.a_ready = 1'b1;

      // Device stalls A: host 0 locked, payload stable, host 1 waits.
      do_reset();
      dev.a_ready = 1'b0;
      h0 = mk_get(32'h3000_0000, 8'd1);
      h1 = mk_get(32'h4000_0000, 8'd2);
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("stall_a_valid", 64'(dev_req.a_valid),   64'd1);
         chk("stall_addr",    64'(dev_req.a_address), 64'h3000_0000);
         chk("stall_src",     64'(dev_req.a_source),  64'd1);
         chk("stall_h1_rdy",  64'(h1_rsp.a_ready),    64'd0);
         tick();
      end
      dev.a_ready = 1'b1;
      settle();
      chk("stall_h0_hs",  64'(h0_rsp.a_ready), 64'd1);
      chk("stall_h1_rdy2", 64'(h1_rsp.a_ready), 64'd0);
      tick();
      settle();
      chk("stall_h1_gnt",  64'(h1_rsp.a_ready),    64'd1);
      chk("stall_h1_addr", 64'(dev_req.a_address), 64'h4000_0000);
      tick();
      hosts_idle();

      // Reset with two outstanding IDs drops them and re-arms host 0 priority.
      rst = 1'b1;
      settle();
      chk("mid_rst_a_valid", 64'(dev_req.a_valid), 64'd0);
      tick();
      rst = 1'b0;
      respond(32'hBAD0, 8'd1);
      settle();
      chk("post_rst_d_ready", 64'(dev_req.d_ready), 64'd1);
      chk("post_rst_h0_dv",   64'(h0_rsp.d_valid),  64'd0);
      chk("post_rst_h1_dv",   64'(h1_rsp.d_valid),  64'd0);
      chk("post_rst_a_valid", 64'(dev_req.a_valid), 64'd0);
      dev = '0; dev.a_ready = 1'b1;
      h0 = mk_get(32'h5000_0000, 8'd0);
      h1 = mk_get(32'h6000_0000, 8'd0);
      settle();
      chk("post_rst_tie_h0", 64'(h0_rsp.a_ready), 64'd1);
      chk("post_rst_tie_h1", 64'(h1_rsp.a_ready), 64'd0);

      // Four outstanding accepted, fifth stalls until a response frees a slot.
      do_reset();
      h0 = mk_get(32'h7000_0000, 8'd4);
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("depth_accept", 64'(h0_rsp.a_ready), 64'd1);
         tick();
      end
      settle();
      chk("depth_5th_rdy",   64'(h0_rsp.a_ready),  64'd0);
      chk("depth_5th_valid", 64'(dev_req.a_valid), 64'd0);
      tick();
      respond(32'h55, 8'd4);
      settle();
      chk("depth_rsp_dv",     64'(h0_rsp.d_valid),  64'd1);
      chk("depth_same_rdy",   64'(h0_rsp.a_ready),  64'd1);
      chk("depth_same_valid", 64'(dev_req.a_valid), 64'd1);
      tick();
      dev = '0; dev.a_ready = 1'b1;
      settle();
      chk("depth_still_full", 64'(h0_rsp.a_ready), 64'd0);

      // Interleaved h0,h1,h0 requests get in-order routed responses.
      do_reset();
      h0 = mk_get(32'h8000_0000, 8'd5);
      settle();
      chk("il_h0_rdy", 64'(h0_rsp.a_ready), 64'd1);
      tick();
      hosts_idle();
      h1 = mk_get(32'h9000_0000, 8'd6);
      settle();
      chk("il_h1_rdy", 64'(h1_rsp.a_ready),   64'd1);
      chk("il_h1_src", 64'(dev_req.a_source), 64'd6);
      tick();
      hosts_idle();
      h0 = mk_get(32'h8000_0004, 8'd7);
      settle();
      chk("il_h0b_rdy", 64'(h0_rsp.a_ready), 64'd1);
      tick();
      hosts_idle();
      respond(32'hA1, 8'd5);
      settle();
      chk("il_r1_h0_dv",   64'(h0_rsp.d_valid), 64'd1);
      chk("il_r1_h0_data", 64'(h0_rsp.d_data),  64'hA1);
      chk("il_r1_h1_dv",   64'(h1_rsp.d_valid), 64'd0);
      tick();
      respond(32'hB2, 8'd6);
      settle();
      chk("il_r2_h1_dv",  64'(h1_rsp.d_valid),  64'd1);
      chk("il_r2_h1_src", 64'(h1_rsp.d_source), 64'd6);
      chk("il_r2_h0_dv",  64'(h0_rsp.d_valid),  64'd0);
      tick();
      respond(32'hC3, 8'd7);
      settle();
      chk("il_r3_h0_dv", 64'(h0_rsp.d_valid), 64'd1);
      chk("il_r3_h1_dv", 64'(h1_rsp.d_valid), 64'd0);
      tick();
      respond(32'hD4, 8'd9);
      settle();
      chk("il_spur_d_ready", 64'(dev_req.d_ready), 64'd1);
      chk("il_spur_h0_dv",   64'(h0_rsp.d_valid),  64'd0);
      chk("il_spur_h1_dv",   64'(h1_rsp.d_valid),  64'd0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
